uart_rx_oversampled: RTL and testbench

- Serial UART receiver that sits directly upstream of the DMA/program-load controller.
- Converts the asynchronous rxd line (8N1, LSB first) into a byte plus a one-cycle rx_ready strobe, matching the rx_ready/rdata inputs the controller consumes.
- Handles metastability, rejects start-bit glitches and flags framing errors.
- Holds the last good byte stable until the next valid frame.

---
 rtl/uart_rx_oversampled.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - oversampled 8N1 UART receiver feeding the program-load controller
//
// Purpose:
//   Recovers bytes from an asynchronous, idle-high serial line (8 data bits,
//   no parity, 1 stop bit, LSB first). The line is synchronized, the start
//   bit is qualified at its midpoint to reject glitches, each data bit and the
//   stop bit are sampled at mid-bit, and a good frame produces a one-cycle
//   rx_ready strobe together with the new byte on rdata. A low stop bit
//   produces a one-cycle ferr strobe instead, and the receiver then waits for
//   the line to return high before looking for another start bit.
//
// Optional build macro:
//   UART_RX_MAJORITY_EN - when defined, every start/data/stop decision is the
//   2-of-3 majority of the synchronized line around the nominal sample point,
//   and the decision is taken one cycle later than in the default build.
//
// Parameters:
//   CLK_PER_BIT  clock cycles per serial bit (>= 8)
//   SYNC_STAGES  flip-flops in the rxd synchronizer (>= 2)
//
// Ports:
//   clock     system clock
//   reset     asynchronous, active-high reset
//   rxd       raw serial input, idles high, asynchronous to clock
//   rx_ready  one-cycle pulse when a valid byte has been received
//   rdata     last valid received byte, held until the next valid frame
//   ferr      one-cycle pulse when the stop bit is sampled low
//   busy      high whenever the receiver is not idle

module uart_rx_oversampled #(
  parameter int CLK_PER_BIT = 868,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  output logic       rx_ready,
  output logic [7:0] rdata,
  output logic       ferr,
  output logic       busy
);

  localparam int CW = $clog2(CLK_PER_BIT);

  // Last counter value of a full bit period; data and stop decisions happen here.
  localparam logic [CW-1:0] BIT_LAST = CW'(CLK_PER_BIT - 1);

`ifdef UART_RX_MAJORITY_EN
  // The start decision is taken one cycle after the half-bit point so the
  // three-sample window is centred on it. Every later decision inherits that
  // one-cycle offset because the counter is cleared on entry to DATA, so the
  // window stays centred on each mid-bit and the bit period is unchanged.
  localparam logic [CW-1:0] START_LAST = CW'(CLK_PER_BIT / 2);
`else
  localparam logic [CW-1:0] START_LAST = CW'(CLK_PER_BIT / 2 - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cycle_cnt;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift_reg;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic                   sample;

  // ---------------------------------------------------------------------------
  // Synchronizer. Reset to all ones so a released reset looks like an idle line.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Bit decision value
  // ---------------------------------------------------------------------------
`ifdef UART_RX_MAJORITY_EN
  // rxs_hist[0] is rxs one cycle ago, rxs_hist[1] two cycles ago. At a
  // decision cycle these are the nominal sample point and the cycle before it,
  // while rxs itself is the cycle after.
  logic [1:0] rxs_hist;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rxs_hist <= '1;
    end else begin
      rxs_hist <= {rxs_hist[0], rxs};
    end
  end

  assign sample = (rxs & rxs_hist[0]) | (rxs & rxs_hist[1]) | (rxs_hist[0] & rxs_hist[1]);
`else
  assign sample = rxs;
`endif

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cycle_cnt <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rdata     <= '0;
      rx_ready  <= 1'b0;
      ferr      <= 1'b0;
    end else begin
      // Strobes are single-cycle by default.
      rx_ready <= 1'b0;
      ferr     <= 1'b0;

      case (state)
        S_IDLE: begin
          cycle_cnt <= '0;
          if (!rxs) begin
            state <= S_START;
          end
        end

        S_START: begin
          if (cycle_cnt == START_LAST) begin
            cycle_cnt <= '0;
            if (sample) begin
              // Line went back high before mid start bit: treat as a glitch.
              state <= S_IDLE;
            end else begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (cycle_cnt == BIT_LAST) begin
            cycle_cnt <= '0;
            // Shift right with the new bit entering at the top, so the first
            // (least significant) bit ends up in bit 0 after eight samples.
            shift_reg <= {sample, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              state <= S_STOP;
            end
          end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (cycle_cnt == BIT_LAST) begin
            cycle_cnt <= '0;
            if (sample) begin
              // Leave mid stop bit so a back-to-back start edge is not missed.
              rdata    <= shift_reg;
              rx_ready <= 1'b1;
              state    <= S_IDLE;
            end else begin
              ferr  <= 1'b1;
              state <= S_BREAK;
            end
          end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
          end
        end

        S_BREAK: begin
          // A line held low would otherwise be read as an endless run of
          // 0x00 frames; wait for it to return to idle first.
          cycle_cnt <= '0;
          if (rxs) begin
            state <= S_IDLE;
          end
        end

        default: begin
          cycle_cnt <= '0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - directed self-checking bench for uart_rx_oversampled

module tb_uart_rx_oversampled;

  localparam int N = 16;

`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 156;
  localparam logic [7:0] GLITCH_BYTE = 8'h00;
`else
  localparam int LAT = 155;
  localparam logic [7:0] GLITCH_BYTE = 8'h08;
`endif

  logic       clock;
  logic       reset;
  logic       rxd;
  logic       rx_ready;
  logic [7:0] rdata;
  logic       ferr;
  logic       busy;

  int checks;
  int failures;

  int cyc;
  int rx_cnt;
  int ferr_cnt;
  int both_cnt;
  logic [7:0] pulse_data;
  int pulse_cyc[$];

  uart_rx_oversampled #(
    .CLK_PER_BIT(N),
    .SYNC_STAGES(2)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .rxd     (rxd),
    .rx_ready(rx_ready),
    .rdata   (rdata),
    .ferr    (ferr),
    .busy    (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    rx_cnt     = 0;
    ferr_cnt   = 0;
    both_cnt   = 0;
    pulse_data = 8'h00;
  end

  always @(negedge clock) begin
    if (rx_ready) begin
      rx_cnt = rx_cnt + 1;
      pulse_data = rdata;
      pulse_cyc.push_back(cyc);
    end
    if (ferr) ferr_cnt = ferr_cnt + 1;
    if (rx_ready && ferr) both_cnt = both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    tick(N);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(N);
    end
    rxd = stop_bit;
    tick(N);
  endtask

  int start_cyc;
  int rx_base;
  int ferr_base;

  initial begin
    checks   = 0;
    failures = 0;
    rxd      = 1'b1;
    reset    = 1'b1;
    tick(3);

    check("reset_rdata", 32'(rdata), 32'h00);
    check("reset_rx_ready", 32'(rx_ready), 32'h0);
    check("reset_ferr", 32'(ferr), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    reset = 1'b0;
    tick(N);

    // Single frame 0x99 with idle before and after
    start_cyc = cyc;
    send_frame(8'h99, 1'b1);
    tick(N);
    check("single_count", 32'(rx_cnt), 32'd1);
    check("single_pulse_data", 32'(pulse_data), 32'h99);
    check("single_rdata", 32'(rdata), 32'h99);
    check("single_ferr", 32'(ferr_cnt), 32'd0);
    check("single_busy", 32'(busy), 32'h0);
    check("single_latency", 32'(pulse_cyc[0] - start_cyc), 32'(LAT));

    // Back-to-back frames, no idle gap
    send_frame(8'h01, 1'b1);
    check("b2b_data0", 32'(pulse_data), 32'h01);
    send_frame(8'h02, 1'b1);
    check("b2b_data1", 32'(pulse_data), 32'h02);
    send_frame(8'h03, 1'b1);
    check("b2b_data2", 32'(pulse_data), 32'h03);
    send_frame(8'h04, 1'b1);
    check("b2b_data3", 32'(pulse_data), 32'h04);
    tick(N);
    check("b2b_count", 32'(rx_cnt), 32'd5);
    check("b2b_gap1", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'd160);
    check("b2b_gap2", 32'(pulse_cyc[3] - pulse_cyc[2]), 32'd160);
    check("b2b_gap3", 32'(pulse_cyc[4] - pulse_cyc[3]), 32'd160);
    check("b2b_rdata", 32'(rdata), 32'h04);

    // Start-bit glitch
    rxd = 1'b0;
    tick(4);
    check("glitch_busy_high", 32'(busy), 32'h1);
    rxd = 1'b1;
    tick(10);
    check("glitch_busy_low", 32'(busy), 32'h0);
    check("glitch_no_rx", 32'(rx_cnt), 32'd5);
    check("glitch_no_ferr", 32'(ferr_cnt), 32'd0);
    tick(N);
    send_frame(8'hAA, 1'b1);
    tick(N);
    check("glitch_then_aa", 32'(rdata), 32'hAA);
    check("glitch_then_count", 32'(rx_cnt), 32'd6);

    // Framing error with preceding good byte 0x12
    send_frame(8'h12, 1'b1);
    tick(N);
    check("ferr_pre_rdata", 32'(rdata), 32'h12);
    rx_base   = rx_cnt;
    ferr_base = ferr_cnt;
    send_frame(8'h55, 1'b0);
    check("ferr_pulse", 32'(ferr_cnt - ferr_base), 32'd1);
    check("ferr_no_rx", 32'(rx_cnt - rx_base), 32'd0);
    check("ferr_rdata_held", 32'(rdata), 32'h12);
    tick(50);
    check("break_no_ferr", 32'(ferr_cnt - ferr_base), 32'd1);
    check("break_no_rx", 32'(rx_cnt - rx_base), 32'd0);
    check("break_busy", 32'(busy), 32'h1);
    rxd = 1'b1;
    tick(N);
    check("break_release_busy", 32'(busy), 32'h0);
    send_frame(8'hAA, 1'b1);
    tick(N);
    check("after_break_rdata", 32'(rdata), 32'hAA);
    check("after_break_rx", 32'(rx_cnt - rx_base), 32'd1);

    // Reset during data bit 4 of 0xC3
    rx_base   = rx_cnt;
    ferr_base = ferr_cnt;
    rxd = 1'b0;
    tick(N);
    for (int i = 0; i < 4; i++) begin
      rxd = (8'hC3 >> i) & 8'h01;
      tick(N);
    end
    rxd = 1'b0;
    tick(8);
    #2 reset = 1'b1;
    #1;
    check("async_reset_rdata", 32'(rdata), 32'h00);
    check("async_reset_rx_ready", 32'(rx_ready), 32'h0);
    check("async_reset_busy", 32'(busy), 32'h0);
    rxd = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(N);
    send_frame(8'h3C, 1'b1);
    tick(N);
    check("post_reset_rdata", 32'(rdata), 32'h3C);
    check("post_reset_rx", 32'(rx_cnt - rx_base), 32'd1);
    check("post_reset_ferr", 32'(ferr_cnt - ferr_base), 32'd0);

    // 0x00 with a one-cycle high glitch at the decision point of bit 3
    rx_base = rx_cnt;
    rxd = 1'b0;
    tick(N);
    tick(3 * N);
    tick(8);
    rxd = 1'b1;
    tick(1);
    rxd = 1'b0;
    tick(7);
    tick(4 * N);
    rxd = 1'b1;
    tick(N);
    tick(N);
    check("midbit_glitch_rdata", 32'(rdata), 32'(GLITCH_BYTE));
    check("midbit_glitch_rx", 32'(rx_cnt - rx_base), 32'd1);

    check("never_both_strobes", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
